// File: rtl/demux_seq_reg.sv
// demux_seq_reg
//   Registered 1-to-CH demultiplexer with valid/ready handshake. Each output
//   channel owns a one-entry register, so a stalled channel only blocks beats
//   aimed at that channel. The target channel is either the external select
//   or an internal round-robin counter that advances once per accepted beat.
//
// Parameters
//   WIDTH  data bits per beat
//   CH     number of output channels (2..256)
//   SELW   select width, 2**SELW >= CH
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   beat can be taken this cycle (independent of in_valid)
//   in_data    input beat
//   sel        external channel select (auto_en = 0)
//   auto_en    1: target = round-robin counter, 0: target = sel
//   out_valid  per-channel beat present
//   out_ready  per-channel consumer ready
//   out_data   channel k at [k*WIDTH +: WIDTH]
//   cur_sel    current target channel (combinational)
//   err_sel    one-cycle pulse after a beat is dropped for an out-of-range sel
//
// Build option
//   DEMUX_ZERO_IDLE_EN  when defined, a channel's data register clears on
//                       drain so idle channels read 0; otherwise data holds.

module demux_seq_reg #(
  parameter int WIDTH = 1,
  parameter int CH    = 8,
  parameter int SELW  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SELW-1:0]       sel,
  input  logic                  auto_en,
  output logic [CH-1:0]         out_valid,
  input  logic [CH-1:0]         out_ready,
  output logic [CH*WIDTH-1:0]   out_data,
  output logic [SELW-1:0]       cur_sel,
  output logic                  err_sel
);

  localparam logic [SELW:0]   CH_LIM  = (SELW+1)'(CH);
  localparam logic [SELW-1:0] RR_LAST = SELW'(CH-1);

  logic [SELW-1:0] rr;
  logic [SELW-1:0] tgt;
  logic            in_range;
  logic            accepted;
  logic [CH-1:0]   hit;
  logic [CH-1:0]   wr;

  always_comb begin
    tgt      = auto_en ? rr : sel;
    in_range = {1'b0, tgt} < CH_LIM;
    hit      = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      hit[k] = (tgt == SELW'(k));
    end
    // Only the addressed channel can stall; an out-of-range target matches
    // no channel, so the beat is always taken (and dropped).
    in_ready = ~|(hit & out_valid & ~out_ready);
    accepted = in_valid & in_ready;
    wr       = accepted ? hit : '0;
  end

  assign cur_sel = tgt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= '0;
      out_data  <= '0;
      rr        <= '0;
      err_sel   <= 1'b0;
    end else begin
      err_sel <= accepted & ~in_range;
      if (accepted && auto_en) begin
        rr <= (rr == RR_LAST) ? '0 : rr + 1'b1;
      end
      for (int unsigned k = 0; k < CH; k++) begin
        // A write wins over a drain so a channel sustains one beat per cycle.
        if (wr[k]) begin
          out_valid[k]                  <= 1'b1;
          out_data[k*WIDTH +: WIDTH]    <= in_data;
        end else if (out_valid[k] && out_ready[k]) begin
          out_valid[k]                  <= 1'b0;
`ifdef DEMUX_ZERO_IDLE_EN
          out_data[k*WIDTH +: WIDTH]    <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_seq_reg.sv
// Self-checking bench for demux_seq_reg (CH=6 so select values 6 and 7 are
// out of range). A queue-free array model tracks each channel's contents
// and the round-robin pointer; every cycle all outputs are compared to it.

module tb_demux_seq_reg;

  localparam int W  = 8;
  localparam int CH = 6;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic [SW-1:0]     sel;
  logic              auto_en;
  logic [CH-1:0]     out_valid;
  logic [CH-1:0]     out_ready;
  logic [CH*W-1:0]   out_data;
  logic [SW-1:0]     cur_sel;
  logic              err_sel;

  demux_seq_reg #(.WIDTH(W), .CH(CH), .SELW(SW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .auto_en   (auto_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cur_sel   (cur_sel),
    .err_sel   (err_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  logic         m_v [CH];
  logic [W-1:0] m_d [CH];
  int           m_rr;
  logic         m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CH-1:0] exp_valid();
    logic [CH-1:0] v;
    for (int k = 0; k < CH; k++) v[k] = m_v[k];
    return v;
  endfunction

  function automatic logic [CH*W-1:0] exp_data();
    logic [CH*W-1:0] d;
    for (int k = 0; k < CH; k++) d[k*W +: W] = m_d[k];
    return d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = '0;
    end
    m_rr  = 0;
    m_err = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check everything, advance the model
  // at the following posedge. Returns just after that posedge.
  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic [SW-1:0] s,
                       input logic ae, input logic [CH-1:0] ordy);
    int   tgt;
    logic rdy;
    logic acc;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    sel       = s;
    auto_en   = ae;
    out_ready = ordy;
    #1;
    tgt = ae ? m_rr : int'(s);
    rdy = (tgt >= CH) || !m_v[tgt] || ordy[tgt];
    check("in_ready",  64'(in_ready),  64'(rdy));
    check("cur_sel",   64'(cur_sel),   64'(tgt));
    check("out_valid", 64'(out_valid), 64'(exp_valid()));
    check("out_data",  64'(out_data),  64'(exp_data()));
    check("err_sel",   64'(err_sel),   64'(m_err));
    acc = iv && rdy;
    @(posedge clk);
    for (int k = 0; k < CH; k++) begin
      if (m_v[k] && ordy[k]) begin
        m_v[k] = 1'b0;
`ifdef DEMUX_ZERO_IDLE_EN
        m_d[k] = '0;
`endif
      end
    end
    m_err = acc && (tgt >= CH);
    if (acc && tgt < CH) begin
      m_v[tgt] = 1'b1;
      m_d[tgt] = d;
    end
    if (acc && ae) m_rr = (m_rr + 1) % CH;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    sel       = '0;
    auto_en   = 1'b0;
    out_ready = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_err",   64'(err_sel),   64'd0);
    reset_n = 1'b1;

    // basic routing to channel 5
    cycle(1'b1, 8'h01, 3'd5, 1'b0, '1);
    #1;
    check("route_valid", 64'(out_valid), 64'b10_0000);
    check("route_data5", 64'(out_data[5*W +: W]), 64'h01);
    cycle(1'b0, 8'h00, 3'd0, 1'b0, '1);

    // round-robin across all channels and past the wrap
    for (int i = 0; i < CH + 2; i++) cycle(1'b1, 8'(8'h10 + i), 3'd0, 1'b1, '1);
    #1;
    check("rr_wrap_sel", 64'(cur_sel), 64'd2);

    // backpressure on channel 2
    cycle(1'b1, 8'hA1, 3'd2, 1'b0, 6'b111011);
    #1;
    check("bp_stall", 64'(in_ready), 64'd0);
    cycle(1'b1, 8'hB2, 3'd2, 1'b0, 6'b111011);
    cycle(1'b1, 8'hB2, 3'd2, 1'b0, '1);
    #1;
    check("bp_valid2", 64'(out_valid[2]), 64'd1);
    check("bp_data2",  64'(out_data[2*W +: W]), 64'hB2);
    cycle(1'b0, 8'h00, 3'd0, 1'b0, '1);

    // out-of-range select
    cycle(1'b1, 8'h77, 3'd7, 1'b0, '1);
    #1;
    check("oor_err", 64'(err_sel), 64'd1);
    check("oor_valid", 64'(out_valid), 64'd0);
    cycle(1'b0, 8'h00, 3'd7, 1'b0, '1);
    #1;
    check("oor_err_clr", 64'(err_sel), 64'd0);

    // fill channels 0..3 then reset between edges
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i), 3'(i), 1'b0, '0);
    cycle(1'b0, 8'h00, 3'd0, 1'b1, '0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_rr",    64'(cur_sel),   64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // mode switch while the round-robin target is stalled
    cycle(1'b1, 8'h33, 3'd3, 1'b0, 6'b110111);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h40 + i), 3'd0, 1'b1, 6'b110111);
    cycle(1'b1, 8'h44, 3'd0, 1'b1, 6'b110111);
    cycle(1'b1, 8'h55, 3'd1, 1'b0, 6'b110111);
    #1;
    check("mode_ch1", 64'(out_data[1*W +: W]), 64'h55);
    cycle(1'b0, 8'h00, 3'd0, 1'b1, 6'b110111);
    #1;
    check("mode_back", 64'(cur_sel), 64'd3);
    cycle(1'b0, 8'h00, 3'd0, 1'b0, '1);

    // drain behaviour of the data register
    cycle(1'b1, 8'hA5, 3'd4, 1'b0, '0);
    cycle(1'b0, 8'h00, 3'd4, 1'b0, '1);
    #1;
    check("drain_valid", 64'(out_valid[4]), 64'd0);
`ifdef DEMUX_ZERO_IDLE_EN
    check("drain_data", 64'(out_data[4*W +: W]), 64'h00);
`else
    check("drain_data", 64'(out_data[4*W +: W]), 64'hA5);
`endif

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom % 4) != 0, 8'($urandom), 3'($urandom), 1'($urandom),
            CH'($urandom) | CH'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
